// File: rtl/mouse_axis_emu.sv
// mouse_axis_emu: PS/2 mouse deltas accumulated into saturating analog stick axes plus merged buttons.
// Define AUTOCENTER_EN to add idle-triggered recentring (DECAY sub-state).
module mouse_axis_emu #(
    parameter int AXW       = 8,
    parameter int DCLAMP    = 10,
    parameter int DSHIFT    = 1,
    parameter int JW        = 21,
`ifdef AUTOCENTER_EN
    parameter int DECAY_DIV = 4096,
    parameter int IDLE_CYC  = 65536,
`endif
    parameter int BTN_LSB   = 4
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic [24:0]      ps2_mouse,
    input  logic [2*AXW-1:0] joya,
    input  logic [JW-1:0]    joy_in,
    input  logic             cpu_halt,
    input  logic             inv_x,
    input  logic             inv_y,
    output logic [AXW-1:0]   ax,
    output logic [AXW-1:0]   ay,
    output logic [JW-1:0]    joy_out,
    output logic             emu_active,
    output logic             pkt_stb
);
    typedef enum logic [1:0] {S_OFF, S_ACT, S_DEC} state_t;

    localparam int PMAX = 2**(AXW-1) - 1;
    localparam int PMIN = -(2**(AXW-1));

    state_t                 r_st, w_nxt;
    logic                   r_stb_q, r_pkt, w_pkt, w_ovr, w_stb;
    logic signed [AXW-1:0]  r_px, r_py, w_px, w_py;
    logic [JW-1:0]          w_joy;
    logic                   w_unused;

    // 9-bit signed delta -> shift, optional invert, per-packet clamp, saturating add
    function automatic logic signed [AXW-1:0] step(input logic signed [AXW-1:0] pos,
                                                   input logic [7:0] d, input logic sg,
                                                   input logic inv);
        int r, s, n;
        r = sg ? int'({sg, d}) - 512 : int'({sg, d});
        s = r >>> DSHIFT;
        s = inv ? -s : s;
        s = (s > DCLAMP) ? DCLAMP : (s < -DCLAMP) ? -DCLAMP : s;
        n = int'(pos) + s;
        n = (n > PMAX) ? PMAX : (n < PMIN) ? PMIN : n;
        return AXW'(n);
    endfunction

    assign w_unused = &{1'b0, ps2_mouse[7:6], ps2_mouse[3:2]};
    assign w_pkt    = ps2_mouse[24] ^ r_stb_q;
    assign w_ovr    = (joya != '0) | cpu_halt;

`ifdef AUTOCENTER_EN
    logic [$clog2(IDLE_CYC+1)-1:0]  r_idle;
    logic [$clog2(DECAY_DIV+1)-1:0] r_div;
    logic                           w_idle_done, w_div_done;
    assign w_idle_done = r_idle == ($bits(r_idle))'(IDLE_CYC - 1);
    assign w_div_done  = r_div == ($bits(r_div))'(DECAY_DIV - 1);

    always_ff @(posedge clk_sys) begin
        if (reset || w_ovr || w_pkt || r_st == S_OFF) begin
            r_idle <= '0;
            r_div  <= '0;
        end else if (r_st == S_ACT) begin
            r_idle <= w_idle_done ? '0 : r_idle + 1'b1;
        end else begin
            r_div  <= w_div_done ? '0 : r_div + 1'b1;
        end
    end
`endif

    always_comb begin
        w_nxt = r_st;
        w_px  = r_px;
        w_py  = r_py;
        w_stb = 1'b0;
        if (w_ovr) begin
            w_nxt = S_OFF;
            w_px  = '0;
            w_py  = '0;
        end else if (w_pkt) begin
            w_nxt = S_ACT;
            w_stb = 1'b1;
            w_px  = step(r_px, ps2_mouse[15:8], ps2_mouse[4], inv_x);
            w_py  = step(r_py, ps2_mouse[23:16], ps2_mouse[5], inv_y);
        end
`ifdef AUTOCENTER_EN
        else if (r_st == S_ACT && w_idle_done) begin
            w_nxt = S_DEC;
        end else if (r_st == S_DEC && w_div_done) begin
            w_px = (r_px > 0) ? r_px - 1'b1 : (r_px < 0) ? r_px + 1'b1 : r_px;
            w_py = (r_py > 0) ? r_py - 1'b1 : (r_py < 0) ? r_py + 1'b1 : r_py;
        end
`endif
    end

    // stb_q follows the strobe even in reset so a toggle seen during reset is discarded
    always_ff @(posedge clk_sys) begin
        r_stb_q <= ps2_mouse[24];
        if (reset) begin
            r_st  <= S_OFF;
            r_px  <= '0;
            r_py  <= '0;
            r_pkt <= 1'b0;
        end else begin
            r_st  <= w_nxt;
            r_px  <= w_px;
            r_py  <= w_py;
            r_pkt <= w_stb;
        end
    end

    always_comb begin
        w_joy = joy_in;
        w_joy[BTN_LSB +: 2] = ps2_mouse[1:0];
    end

    assign emu_active = r_st != S_OFF;
    assign pkt_stb    = r_pkt;
    assign ax         = emu_active ? r_px : joya[AXW-1:0];
    assign ay         = emu_active ? r_py : joya[2*AXW-1:AXW];
    assign joy_out    = emu_active ? w_joy : joy_in;
endmodule

// File: tb/tb_mouse_axis_emu.sv
// tb_mouse_axis_emu: scoreboard bench for the default mouse_axis_emu build.
module tb_mouse_axis_emu;
    logic        clk_sys = 1'b0;
    logic        reset, cpu_halt, inv_x, inv_y, emu_active, pkt_stb;
    logic [24:0] ps2_mouse;
    logic [15:0] joya;
    logic [20:0] joy_in, joy_out;
    logic [7:0]  ax, ay;

    typedef struct packed {
        logic [7:0]  ax;
        logic [7:0]  ay;
        logic [20:0] jo;
        logic        emu;
        logic        stb;
    } exp_t;

    exp_t q[$];
    int   errs = 0, checks = 0;
    int   mx = 0, my = 0;
    logic memu = 1'b0;

    mouse_axis_emu dut (
        .clk_sys(clk_sys), .reset(reset), .ps2_mouse(ps2_mouse), .joya(joya),
        .joy_in(joy_in), .cpu_halt(cpu_halt), .inv_x(inv_x), .inv_y(inv_y),
        .ax(ax), .ay(ay), .joy_out(joy_out), .emu_active(emu_active), .pkt_stb(pkt_stb)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int model_step(input int p, input logic [7:0] d, input logic sg,
                                      input logic inv);
        int r, s;
        r = sg ? int'(d) - 256 : int'(d);
        s = (r < 0) ? (r - 1) / 2 : r / 2;
        if (inv) s = -s;
        if (s > 10) s = 10;
        if (s < -10) s = -10;
        p = p + s;
        if (p > 127) p = 127;
        if (p < -128) p = -128;
        return p;
    endfunction

    task automatic push_exp(input logic stb);
        exp_t e;
        e.emu = memu;
        e.stb = stb;
        e.ax  = memu ? 8'(mx) : joya[7:0];
        e.ay  = memu ? 8'(my) : joya[15:8];
        e.jo  = joy_in;
        if (memu) e.jo[5:4] = ps2_mouse[1:0];
        q.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk_sys);
        #1;
        e = q.pop_front();
        chk("ax", 32'(ax), 32'(e.ax));
        chk("ay", 32'(ay), 32'(e.ay));
        chk("joy_out", 32'(joy_out), 32'(e.jo));
        chk("emu_active", 32'(emu_active), 32'(e.emu));
        chk("pkt_stb", 32'(pkt_stb), 32'(e.stb));
    endtask

    task automatic idle();
        if (joya != 0 || cpu_halt) begin
            mx = 0; my = 0; memu = 1'b0;
        end
        push_exp(1'b0);
        tick();
    endtask

    task automatic send(input logic [7:0] dx, input logic sx, input logic [7:0] dy,
                        input logic sy);
        ps2_mouse[24]    = ~ps2_mouse[24];
        ps2_mouse[15:8]  = dx;
        ps2_mouse[23:16] = dy;
        ps2_mouse[4]     = sx;
        ps2_mouse[5]     = sy;
        if (joya != 0 || cpu_halt) begin
            mx = 0; my = 0; memu = 1'b0;
            push_exp(1'b0);
        end else begin
            mx = model_step(mx, dx, sx, inv_x);
            my = model_step(my, dy, sy, inv_y);
            memu = 1'b1;
            push_exp(1'b1);
        end
        tick();
    endtask

    initial begin
        reset = 1'b1; ps2_mouse = '0; joya = '0; joy_in = '0;
        cpu_halt = 1'b0; inv_x = 1'b0; inv_y = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1 reset = 1'b0;
        idle();
        send(8'h05, 1'b0, 8'h00, 1'b0);
        chk("first_pos_x", 32'(ax), 32'd2);
        idle();
        repeat (20) send(8'hFF, 1'b0, 8'h00, 1'b0);
        chk("x_sat_max", 32'(ax), 32'd127);
        inv_y = 1'b1;
        send(8'h00, 1'b0, 8'hEC, 1'b1);
        chk("y_inv_pos", 32'(ay), 32'd10);
        inv_y = 1'b0;
        repeat (15) send(8'h00, 1'b0, 8'hEC, 1'b1);
        chk("y_sat_min", 32'(ay), 32'h80);
        inv_x = 1'b1;
        send(8'h14, 1'b0, 8'h00, 1'b0);
        inv_x = 1'b0;
        ps2_mouse[1:0] = 2'b01;
        idle();
        chk("btn_merge", 32'(joy_out), 32'h10);
        joy_in = 21'h1ABCDE;
        ps2_mouse[1:0] = 2'b10;
        idle();
        cpu_halt = 1'b1;
        idle();
        cpu_halt = 1'b0;
        repeat (5) send(8'hFF, 1'b0, 8'h00, 1'b0);
        chk("pos_x_50", 32'(ax), 32'd50);
        joya = 16'h0030;
        send(8'h05, 1'b0, 8'h00, 1'b0);
        chk("ovr_ax", 32'(ax), 32'h30);
        joya = '0;
        idle();
        send(8'h05, 1'b0, 8'h03, 1'b0);
        cpu_halt = 1'b1;
        send(8'h05, 1'b0, 8'h00, 1'b0);
        cpu_halt = 1'b0;
        idle();
        send(8'h0A, 1'b0, 8'hF6, 1'b1);
        reset = 1'b1;
        ps2_mouse[24] = ~ps2_mouse[24];
        @(posedge clk_sys);
        #1 reset = 1'b0;
        mx = 0; my = 0; memu = 1'b0;
        idle();
        idle();
        send(8'h07, 1'b0, 8'h00, 1'b0);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
